// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, widths
// and the packed result-buffer entry.
package alu_pkg;

  localparam int ALU_W   = 4;
  localparam int ENTRY_W = 10;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [ALU_W-1:0] result;
    logic             carry;
    logic             overflow;
    logic             equal;
  } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers;
// storage is not reset, only the pointers.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW])
              && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Write the tail slot on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Advance pointers; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Buffers ALU results for a consumer and keeps
// sticky carry/overflow plus an overflow counter.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opcode,
  input  logic [ALU_W-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic             in_equal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_opcode,
  output logic [ALU_W-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_equal,
  output logic [LW-1:0]    level,
  input  logic             sticky_clr,
  output logic             sticky_carry,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] ovf_count
);

  entry_t wr_entry;
  entry_t rd_entry;
  entry_t head;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wr_entry = '{
    opcode:   in_opcode,
    result:   in_result,
    carry:    in_carry,
    overflow: in_overflow,
    equal:    in_equal
  };

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(wr_entry),
    .rdata(rd_entry),
    .full (full),
    .empty(empty),
    .level(level)
  );

  assign head         = empty ? '0 : rd_entry;
  assign out_opcode   = head.opcode;
  assign out_result   = head.result;
  assign out_carry    = head.carry;
  assign out_overflow = head.overflow;
  assign out_equal    = head.equal;

  // Sticky flags: a same-cycle set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_carry <= 1'b0;
      sticky_ovf   <= 1'b0;
    end else begin
      sticky_carry <= (sticky_carry & ~sticky_clr)
                    | (push & in_carry);
      sticky_ovf   <= (sticky_ovf & ~sticky_clr)
                    | (push & in_overflow);
    end
  end

  // Saturating count of accepted overflow entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (push && in_overflow && (ovf_count != '1)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer; a second
// instance with a 2-bit counter covers saturation.
module tb_alu_result_buffer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_opcode;
  logic [3:0] in_result;
  logic       in_carry;
  logic       in_overflow;
  logic       in_equal;
  logic       out_ready;
  logic       sticky_clr;

  logic       in_ready, out_valid;
  logic [2:0] out_opcode;
  logic [3:0] out_result;
  logic       out_carry, out_overflow, out_equal;
  logic [2:0] level;
  logic       sticky_carry, sticky_ovf;
  logic [7:0] ovf_count;

  logic       d2_in_ready, d2_out_valid;
  logic [2:0] d2_out_opcode;
  logic [3:0] d2_out_result;
  logic       d2_out_carry, d2_out_overflow, d2_out_equal;
  logic [2:0] d2_level;
  logic       d2_sticky_carry, d2_sticky_ovf;
  logic [1:0] d2_ovf_count;

  int tests = 0;
  int fails = 0;
  logic [3:0] q[$];

  always #5 clk = ~clk;

  alu_result_buffer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_result(in_result),
    .in_carry(in_carry), .in_overflow(in_overflow),
    .in_equal(in_equal),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_result(out_result),
    .out_carry(out_carry), .out_overflow(out_overflow),
    .out_equal(out_equal), .level(level),
    .sticky_clr(sticky_clr),
    .sticky_carry(sticky_carry), .sticky_ovf(sticky_ovf),
    .ovf_count(ovf_count)
  );

  alu_result_buffer #(.DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_opcode(in_opcode), .in_result(in_result),
    .in_carry(in_carry), .in_overflow(in_overflow),
    .in_equal(in_equal),
    .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_opcode(d2_out_opcode), .out_result(d2_out_result),
    .out_carry(d2_out_carry), .out_overflow(d2_out_overflow),
    .out_equal(d2_out_equal), .level(d2_level),
    .sticky_clr(sticky_clr),
    .sticky_carry(d2_sticky_carry), .sticky_ovf(d2_sticky_ovf),
    .ovf_count(d2_ovf_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] res,
                       input logic c, input logic v, input logic e);
    in_valid    = 1'b1;
    in_opcode   = op;
    in_result   = res;
    in_carry    = c;
    in_overflow = v;
    in_equal    = e;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_opcode   = '0;
    in_result   = '0;
    in_carry    = 1'b0;
    in_overflow = 1'b0;
    in_equal    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    sticky_clr = 1'b0;
    idle();
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf_count", ovf_count, 0);
    rst = 1'b0;

    // 1: async reset with three entries held
    drive(OP_ADD, 4'd1, 1, 1, 0); tick();
    drive(OP_SUB, 4'd2, 1, 1, 0); tick();
    drive(OP_AND, 4'd3, 1, 1, 0); tick();
    idle();
    chk("t1_level3", level, 3);
    chk("t1_ovf3", ovf_count, 3);
    chk("t1_sticky_pre", {sticky_carry, sticky_ovf}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_level", level, 0);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_sticky", {sticky_carry, sticky_ovf}, 2'b00);
    chk("t1_ovf", ovf_count, 0);
    chk("t1_out_result", out_result, 0);
    rst = 1'b0;
    tick();

    // 2: single push, head appears next cycle
    drive(OP_ADD, 4'b1000, 1, 1, 0);
    chk("t2_pre_valid", out_valid, 0);
    tick();
    idle();
    chk("t2_valid", out_valid, 1);
    chk("t2_result", out_result, 4'b1000);
    chk("t2_opcode", out_opcode, OP_ADD);
    chk("t2_flags", {out_carry, out_overflow, out_equal}, 3'b110);
    chk("t2_sticky_ovf", sticky_ovf, 1);
    chk("t2_sticky_carry", sticky_carry, 1);
    chk("t2_ovf", ovf_count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_drained", level, 0);
    chk("t2_gate_result", out_result, 0);
    chk("t2_gate_flags", {out_carry, out_overflow}, 2'b00);

    // 3: fill to full, fifth push refused, drain in order
    for (int i = 1; i <= 5; i++) begin
      drive(OP_OR, 4'(i), 0, 0, 0);
      tick();
      if (i == 4) begin
        chk("t3_full_ready", in_ready, 0);
        chk("t3_full_level", level, 4);
      end
    end
    idle();
    chk("t3_after5_level", level, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_order", out_result, 32'(i));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk("t3_empty", out_valid, 0);

    // 4: concurrent push/pop at level 2 across pointer wrap
    q.delete();
    drive(OP_XOR, 4'd9, 0, 0, 0); q.push_back(4'd9); tick();
    drive(OP_XOR, 4'd10, 0, 0, 0); q.push_back(4'd10); tick();
    chk("t4_level2", level, 2);
    for (int k = 0; k < 10; k++) begin
      logic [3:0] nv;
      nv = 4'(11 + k);
      drive(OP_XOR, nv, 0, 0, 0);
      out_ready = 1'b1;
      chk("t4_head", out_result, 32'(q[0]));
      tick();
      void'(q.pop_front());
      q.push_back(nv);
      chk("t4_level", level, 2);
    end
    idle();
    while (q.size() > 0) begin
      chk("t4_drain", out_result, 32'(q[0]));
      void'(q.pop_front());
      tick();
    end
    out_ready = 1'b0;
    chk("t4_empty", level, 0);

    // 5: set beats clear, then clear alone
    sticky_clr = 1'b1;
    drive(OP_ADD, 4'd7, 0, 1, 0);
    tick();
    idle();
    chk("t5_set_wins", sticky_ovf, 1);
    tick();
    sticky_clr = 1'b0;
    chk("t5_cleared_ovf", sticky_ovf, 0);
    chk("t5_cleared_carry", sticky_carry, 0);
    chk("t5_ovf", ovf_count, 2);
    chk("t5_d2_ovf", d2_ovf_count, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 6: 2-bit counter saturates; equal flag survives
    for (int i = 0; i < 5; i++) begin
      drive(OP_SUB, 4'd8, 0, 1, 0);
      out_ready = 1'b1;
      tick();
    end
    chk("t6_sat", d2_ovf_count, 3);
    chk("t6_wide", ovf_count, 7);
    drive(OP_EQ, 4'b0001, 0, 0, 1);
    tick();
    idle();
    out_ready = 1'b0;
    chk("t6_eq", out_equal, 1);
    chk("t6_eq_op", out_opcode, OP_EQ);
    chk("t6_eq_res", out_result, 1);
    chk("t6_d2_eq", d2_out_equal, 1);
    chk("t6_d2_level", d2_level, 1);
    chk("t6_sat_hold", d2_ovf_count, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
